// File: rtl/md_pkg.sv
// Shared opcodes, FSM states and per-op context for the HI/LO multiply/divide unit.
package md_pkg;

  localparam int unsigned MD_WIDTH = 32;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

  // Everything about the accepted op that the final sign-fix step needs
  typedef struct packed {
    logic [2:0] op;
    logic       neg_res;
    logic       neg_rem;
    logic       b_zero;
  } md_ctx_t;

endpackage

// File: rtl/md_iter_datapath.sv
// One-bit-per-clock shift-add multiplier / restoring divider on a 2*WIDTH accumulator.
module md_iter_datapath
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   init_a,
  input  logic [WIDTH-1:0]   init_b,
  output logic [2*WIDTH-1:0] acc
);

  logic [WIDTH-1:0]   opb_q;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_d;

  // Mul: add multiplicand on LSB then shift right. Div: shift left, keep trial subtract if no borrow.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb_q : '0)};
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    if (is_div) begin
      if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                  acc_d = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      acc   <= '0;
      opb_q <= '0;
    end else if (load) begin
      acc   <= {{WIDTH{1'b0}}, init_a};
      opb_q <= init_b;
    end else if (step) begin
      acc   <= acc_d;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS HI/LO unit: iterative MULT/MULTU/DIV/DIVU (WIDTH+1 clocks) and single-cycle MTHI/MTLO.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW    = 2 * WIDTH;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_ctx_t          ctx_q, ctx_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             busy_d, done_d, dbz_d;
  logic             dp_load, dp_step, is_div_q;
  logic             is_signed_op, sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b, quo, rem;
  logic [PW-1:0]    acc, prod;

  // Signed ops run on magnitudes; the sign is reapplied in FIX
  assign is_signed_op = (op == MD_MULT) || (op == MD_DIV);
  assign sign_a       = is_signed_op & operand_a[WIDTH-1];
  assign sign_b       = is_signed_op & operand_b[WIDTH-1];
  assign abs_a        = sign_a ? (~operand_a + WIDTH'(1)) : operand_a;
  assign abs_b        = sign_b ? (~operand_b + WIDTH'(1)) : operand_b;
  assign is_div_q     = (ctx_q.op == MD_DIV) || (ctx_q.op == MD_DIVU);

  assign prod = ctx_q.neg_res ? (~acc + PW'(1)) : acc;
  assign quo  = ctx_q.neg_res ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
  assign rem  = ctx_q.neg_rem ? (~acc[PW-1:WIDTH] + WIDTH'(1)) : acc[PW-1:WIDTH];

  md_iter_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clock  (clock),
    .reset  (reset),
    .load   (dp_load),
    .step   (dp_step),
    .is_div (is_div_q),
    .init_a (abs_a),
    .init_b (abs_b),
    .acc    (acc)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctx_d   = ctx_q;
    a_raw_d = a_raw_q;
    hi_d    = hi;
    lo_d    = lo;
    busy_d  = busy;
    done_d  = 1'b0;
    dbz_d   = div_by_zero;
    dp_load = 1'b0;
    dp_step = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          if (op <= MD_DIVU) begin
            dp_load       = 1'b1;
            state_d       = S_RUN;
            cnt_d         = '0;
            busy_d        = 1'b1;
            dbz_d         = 1'b0;
            a_raw_d       = operand_a;
            ctx_d.op      = op;
            ctx_d.neg_res = sign_a ^ sign_b;
            ctx_d.neg_rem = sign_a;
            ctx_d.b_zero  = (operand_b == '0);
          end else if (op == MD_MTHI) begin
            hi_d   = operand_a;
            done_d = 1'b1;
            dbz_d  = 1'b0;
          end else if (op == MD_MTLO) begin
            lo_d   = operand_a;
            done_d = 1'b1;
            dbz_d  = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          dp_step = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = S_FIX;
            cnt_d   = '0;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (!cancel) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod[PW-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (ctx_q.b_zero) begin
            hi_d  = a_raw_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ctx_q       <= '0;
      a_raw_q     <= '0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctx_q       <= ctx_d;
      a_raw_q     <= a_raw_d;
      hi          <= hi_d;
      lo          <= lo_d;
      busy        <= busy_d;
      done        <= done_d;
      div_by_zero <= dbz_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .cancel      (cancel),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one iterative op, wait for done, check latency, busy span and results
  task automatic run_vec(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dbz);
    int lat;
    int bcnt;
    @(negedge clock);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clock);
    start = 1'b0; operand_a = 32'h5A5A_A5A5; operand_b = 32'h0F0F_F0F0;
    lat = 0;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clock);
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(33));
    check({tag, ".busy_cycles"}, 64'(bcnt), 64'(33));
    check({tag, ".hi"}, 64'(hi), 64'(exp_hi));
    check({tag, ".lo"}, 64'(lo), 64'(exp_lo));
    check({tag, ".dbz"}, 64'(div_by_zero), 64'(exp_dbz));
    @(negedge clock);
    check({tag, ".done_pulse"}, 64'(done), 64'(0));
  endtask

  // Single-cycle MTHI/MTLO
  task automatic run_mt(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clock);
    start = 1'b1; op = o; operand_a = a; operand_b = 32'h0;
    @(negedge clock);
    start = 1'b0;
    check({tag, ".done"}, 64'(done), 64'(1));
    check({tag, ".busy"}, 64'(busy), 64'(0));
    check({tag, ".hi"}, 64'(hi), 64'(exp_hi));
    check({tag, ".lo"}, 64'(lo), 64'(exp_lo));
    check({tag, ".dbz"}, 64'(div_by_zero), 64'(0));
    @(negedge clock);
    check({tag, ".done_pulse"}, 64'(done), 64'(0));
    check({tag, ".busy_after"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int lat;
    int dcnt;
    reset = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'd0;
    operand_a = 32'h0; operand_b = 32'h0;
    repeat (3) @(negedge clock);
    check("reset.busy", 64'(busy), 64'(0));
    check("reset.done", 64'(done), 64'(0));
    check("reset.hi", 64'(hi), 64'(0));
    check("reset.lo", 64'(lo), 64'(0));
    check("reset.dbz", 64'(div_by_zero), 64'(0));
    reset = 1'b1;

    run_vec("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_vec("mult_neg3x5", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_vec("mult_neg4xneg4", 3'd0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h10, 1'b0);
    run_vec("multu_msbx2", 3'd1, 32'h8000_0000, 32'd2, 32'h1, 32'h0, 1'b0);
    run_vec("divu_7_2", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    run_vec("divu_max_16", 3'd3, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 1'b0);
    run_vec("div_neg7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_vec("div_7_neg2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_vec("div_min_neg1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_vec("div_neg_by0", 3'd2, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
    run_vec("div_by0", 3'd2, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);

    run_mt("mthi", 3'd4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    run_mt("mtlo", 3'd5, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'hCAFE_F00D);

    // start of DIVU while MULT is in flight is ignored
    @(negedge clock);
    start = 1'b1; op = 3'd0; operand_a = 32'd100; operand_b = 32'hFFFF_FFFE;
    @(negedge clock);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == 4) begin
        start = 1'b1; op = 3'd3; operand_a = 32'd9; operand_b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      lat++;
    end
    start = 1'b0;
    check("busy_start.latency", 64'(lat), 64'(33));
    check("busy_start.hi", 64'(hi), 64'(32'hFFFF_FFFF));
    check("busy_start.lo", 64'(lo), 64'(32'hFFFF_FF38));
    @(negedge clock);
    check("busy_start.no_requeue", 64'(busy), 64'(0));

    // cancel at cycle 10 of a DIVU: no done, HI/LO keep the MULT result
    start = 1'b1; op = 3'd3; operand_a = 32'd100; operand_b = 32'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    check("cancel.busy_before", 64'(busy), 64'(1));
    cancel = 1'b1;
    @(negedge clock);
    cancel = 1'b0;
    check("cancel.busy", 64'(busy), 64'(0));
    dcnt = 0;
    repeat (40) begin
      if (done) dcnt++;
      @(negedge clock);
    end
    check("cancel.no_done", 64'(dcnt), 64'(0));
    check("cancel.hi", 64'(hi), 64'(32'hFFFF_FFFF));
    check("cancel.lo", 64'(lo), 64'(32'hFFFF_FF38));

    // cancel blocks a same-cycle start in IDLE; op 6 is a no-op
    start = 1'b1; cancel = 1'b1; op = 3'd1; operand_a = 32'd3; operand_b = 32'd3;
    @(negedge clock);
    start = 1'b0; cancel = 1'b0;
    check("cancel_idle.busy", 64'(busy), 64'(0));
    start = 1'b1; op = 3'd6; operand_a = 32'h1111_1111;
    @(negedge clock);
    start = 1'b0;
    check("nop.done", 64'(done), 64'(0));
    check("nop.busy", 64'(busy), 64'(0));
    check("nop.hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FF38});

    // reset at cycle 12 of a DIV, with start held during reset
    start = 1'b1; op = 3'd2; operand_a = 32'd1000; operand_b = 32'd3;
    @(negedge clock);
    start = 1'b0;
    repeat (11) @(negedge clock);
    reset = 1'b0; start = 1'b1; op = 3'd1; operand_a = 32'd5; operand_b = 32'd5;
    @(negedge clock);
    check("rst_mid.hilo", {hi, lo}, 64'h0);
    check("rst_mid.busy", 64'(busy), 64'(0));
    check("rst_mid.done", 64'(done), 64'(0));
    check("rst_mid.dbz", 64'(div_by_zero), 64'(0));
    @(negedge clock);
    reset = 1'b1; start = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_mid.busy_after", 64'(busy), 64'(0));
    check("rst_mid.hilo_after", {hi, lo}, 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
